// File: rtl/dma_sram_fifo_ctrl.sv
// dma_sram_fifo_ctrl: FIFO controller in front of a small synchronous micro-RAM.
// Words are written straight into the RAM, read back through a two-cycle
// read pipeline and landed in a small register skid buffer. The skid buffer
// drives the downstream port, so RD_DATA is always a flop output.
//
// Handshake semantics (both ports): a transfer happens on a rising CLK edge
// exactly when valid and ready are both 1 in that cycle. A producer never
// withdraws or changes data based on ready. WR_READY is derived from registered
// state (and SRST) only. RD_VALID/RD_DATA come from registers only and hold
// steady until the word is consumed.
module dma_sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 50,
  parameter int ADDR_WIDTH = 2,
  parameter int SKID_DEPTH = 3
) (
  input  logic                  CLK,
  input  logic                  SRST,
  // upstream
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  // downstream
  output logic                  RD_VALID,
  input  logic                  RD_READY,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [2:0]            LEVEL,
  // RAM side
  output logic                  RAM_W_EN,
  output logic [ADDR_WIDTH-1:0] RAM_W_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_W_DATA,
  output logic [ADDR_WIDTH-1:0] RAM_R_ADDR,
  output logic                  RAM_R_ADDR_EN,
  output logic                  RAM_R_DATA_EN,
  input  logic [DATA_WIDTH-1:0] RAM_R_DATA,
  output logic                  RAM_BLK_EN,
  output logic                  RAM_R_ADDR_SRST_N,
  output logic                  RAM_R_DATA_SRST_N
);

  localparam int PW = ADDR_WIDTH + 1;              // pointer: address plus wrap bit
  localparam int CW = $clog2(SKID_DEPTH + 1);      // skid occupancy counter width
  localparam logic [CW:0] SKID_LIM = (CW + 1)'(SKID_DEPTH);

  // pointers, read pipeline valids, skid buffer
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  rd_s1_q, rd_s1_d;       // address issued last cycle (RAM data enable now)
  logic                  rd_s2_q, rd_s2_d;       // RAM data on RAM_R_DATA now, captured this edge
  logic [CW-1:0]         skid_cnt_q, skid_cnt_d;
  logic [DATA_WIDTH-1:0] skid_mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] skid_mem_d [SKID_DEPTH];

  logic [PW-1:0] ram_count;
  logic          ram_full;
  logic          ram_empty;
  logic [CW:0]   committed;
  logic [CW:0]   committed_after_pop;
  logic          wr_fire;
  logic          pop;
  logic          issue;

  // RAM occupancy comes only from registered pointers, so a word written this
  // cycle is not readable until the next one.
  assign ram_count = wptr_q - rptr_q;
  assign ram_full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                     (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
  assign ram_empty = (wptr_q == rptr_q);

  // Skid slots already spoken for: words in the skid plus reads in flight.
  // A pop this cycle frees a slot in time for a read issued now, which is what
  // lets the three-cycle read loop sustain one word per cycle.
  assign committed           = (CW + 1)'(skid_cnt_q) + (CW + 1)'(rd_s1_q) + (CW + 1)'(rd_s2_q);
  assign committed_after_pop = committed - (CW + 1)'(pop);

  assign WR_READY = !ram_full && !SRST;
  assign wr_fire  = WR_VALID && WR_READY;
  assign RD_VALID = (skid_cnt_q != '0);
  assign RD_DATA  = skid_mem_q[0];
  assign pop      = RD_VALID && RD_READY;
  assign issue    = !SRST && !ram_empty && (committed_after_pop < SKID_LIM);

  assign RAM_W_EN          = wr_fire;
  assign RAM_W_ADDR        = wptr_q[ADDR_WIDTH-1:0];
  assign RAM_W_DATA        = WR_DATA;
  assign RAM_R_ADDR        = rptr_q[ADDR_WIDTH-1:0];
  assign RAM_R_ADDR_EN     = issue;
  assign RAM_R_DATA_EN     = rd_s1_q;
  assign RAM_BLK_EN        = 1'b1;
  assign RAM_R_ADDR_SRST_N = !SRST;
  assign RAM_R_DATA_SRST_N = !SRST;

  // Total words held anywhere in the controller; bounded by RAM depth plus skid depth.
  assign LEVEL = 3'(ram_count) + 3'(rd_s1_q) + 3'(rd_s2_q) + 3'(skid_cnt_q);

  // Next-state: pointer advance, read pipeline shift, skid pop/capture.
  always_comb begin
    wptr_d     = wptr_q + PW'(wr_fire);
    rptr_d     = rptr_q + PW'(issue);
    rd_s1_d    = issue;
    rd_s2_d    = rd_s1_q;
    skid_cnt_d = skid_cnt_q;
    skid_mem_d = skid_mem_q;
    if (pop) begin
      for (int i = 0; i < SKID_DEPTH - 1; i++) begin
        skid_mem_d[i] = skid_mem_q[i + 1];
      end
      skid_cnt_d = skid_cnt_q - 1'b1;
    end
    if (rd_s2_q) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        if (CW'(i) == skid_cnt_d) begin
          skid_mem_d[i] = RAM_R_DATA;
        end
      end
      skid_cnt_d = skid_cnt_d + 1'b1;
    end
  end

  // Control state register with synchronous reset; reset drops every stored
  // and in-flight word.
  always_ff @(posedge CLK) begin
    if (SRST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_s1_q    <= 1'b0;
      rd_s2_q    <= 1'b0;
      skid_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_s1_q    <= rd_s1_d;
      rd_s2_q    <= rd_s2_d;
      skid_cnt_q <= skid_cnt_d;
    end
  end

  // Skid data storage; contents are meaningless while skid_cnt_q marks them empty.
  always_ff @(posedge CLK) begin
    skid_mem_q <= skid_mem_d;
  end

endmodule
